// File: rtl/gpio_cap_pkg.sv
// gpio_cap_pkg
//   Shared types and helpers for the GPIO edge-capture input stage.
//   - deb_state_e : per-pin debounce FSM state
//   - cnt_w()     : width of the debounce counter for a given cycle count
package gpio_cap_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

  // A counter that must reach n-1 needs $clog2(n) bits; never go below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit
//   One GPIO pin: synchroniser chain, debounce FSM and persistence counter.
//   Ports:
//     clk_i    : clock, all logic on posedge
//     rst_i    : synchronous active-high reset
//     pin_i    : raw asynchronous pin
//     level_o  : debounced level (registered)
//     accept_o : high in the cycle whose closing edge loads a new level into level_o
module gpio_debounce_bit
  import gpio_cap_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic accept_o
);

  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   differ_s;
  logic                   accept_s;
  logic                   level_q;
  logic [CNT_W-1:0]       cnt_q;
  deb_state_e             state_q;

  // Synchroniser shift chain; the last stage is the only one the FSM looks at.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign differ_s = sync_s ^ level_q;

  // Accept decision: immediate when no filtering is configured, otherwise on
  // the last counting cycle while the new level still persists.
  always_comb begin
    accept_s = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (DEBOUNCE_CYCLES == 1) accept_s = differ_s;
        else                      accept_s = 1'b0;
      end
      ST_COUNT: begin
        if (cnt_q == CNT_MAX) accept_s = differ_s;
        else                  accept_s = 1'b0;
      end
      default: accept_s = 1'b0;
    endcase
  end

  // Debounce FSM, persistence counter and debounced level register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      if (accept_s) level_q <= sync_s;
      case (state_q)
        ST_STABLE: begin
          if (differ_s && (DEBOUNCE_CYCLES > 1)) begin
            cnt_q   <= CNT_ONE;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Either the level fell back (glitch) or it was just accepted.
          if (!differ_s || (cnt_q == CNT_MAX)) begin
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_STABLE;
        end
      endcase
    end
  end

  assign level_o  = level_q;
  assign accept_o = accept_s;

endmodule

// File: rtl/gpio_edge_capture.sv
// gpio_edge_capture
//   GPIO input stage: per-pin sync + debounce, edge detection into sticky
//   write-one-to-clear status, and a level interrupt.
//   Ports:
//     clk_i     : clock, all logic on posedge
//     rst_i     : synchronous active-high reset
//     gpio_i    : raw asynchronous pins
//     rise_en_i : per-bit enable, rising debounced edge sets status
//     fall_en_i : per-bit enable, falling debounced edge sets status
//     clr_i     : per-bit clear pulse for status (set wins)
//     gpio_o    : debounced levels (registered)
//     status_o  : sticky edge status (registered)
//     irq_o     : OR of the status flops
module gpio_edge_capture
  import gpio_cap_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] status_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] accept_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] status_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pin_i    (gpio_i[gi]),
      .level_o  (level_s[gi]),
      .accept_o (accept_s[gi])
    );
  end

  // An accept only happens when the synchronised level differs from the
  // current debounced level, so the incoming level is ~level_s.
  assign rise_s = accept_s & ~level_s & rise_en_i;
  assign fall_s = accept_s &  level_s & fall_en_i;

  // Next status: clear requested bits, then OR in new events so set wins.
  always_comb begin
    status_d = (status_q & ~clr_i) | rise_s | fall_s;
  end

  // Sticky status register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign gpio_o   = level_s;
  assign status_o = status_q;
  assign irq_o    = |status_q;

endmodule
